// File: rtl/pic_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } pic_state_e;

  localparam logic EOI_NONSPEC  = 1'b0;
  localparam logic EOI_SPECIFIC = 1'b1;

  // Rank 0 is the highest priority, i.e. the channel just after lp.
  function automatic int prio_rank(input int idx, input int lp, input int n);
    int r;
    r = idx + n - lp - 1;
    if (r >= n) r = r - n;
    return r;
  endfunction

endpackage

// File: rtl/prio_resolver.sv
// Rotating find-first-set: scans from channel lp+1 upward, wrapping, to lp.
module prio_resolver #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] lp,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int c;
    valid = 1'b0;
    idx   = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int j = N - 1; j >= 0; j--) begin
      c = int'(lp) + 1 + j;
      if (c >= N) c = c - N;
      if (req[c[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_prio_core.sv
// Fully nested rotating-priority interrupt controller with two-pulse acknowledge.
//   state | meaning
//   IDLE  | no request presented to the CPU
//   PEND  | INT asserted, waiting for first INTA
//   ACK   | winner (or spurious vector) latched, waiting for second INTA
module irq_prio_core
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8,
  localparam int IDX_W  = $clog2(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               CFG_LEVEL,
  input  logic               CFG_AEOI,
  input  logic               CFG_ROTATE,
  input  logic [VEC_W-1:0]   VEC_BASE,
  input  logic               IMR_WE,
  input  logic [NUM_IRQ-1:0] IMR_DIN,
  input  logic               EOI_CMD,
  input  logic               EOI_SPEC,
  input  logic [IDX_W-1:0]   EOI_IDX,
  input  logic               INTA,
  output logic               INT,
  output logic [VEC_W-1:0]   VEC,
  output logic               VEC_VALID,
  output logic [NUM_IRQ-1:0] IRR,
  output logic [NUM_IRQ-1:0] ISR,
  output logic [NUM_IRQ-1:0] IMR
);

  localparam logic [NUM_IRQ-1:0] ONE      = NUM_IRQ'(1);
  localparam logic [VEC_W-1:0]   IDX_MASK = VEC_W'((1 << IDX_W) - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_IRQ - 1);

  pic_state_e         state;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [IDX_W-1:0]   lp;
  logic [IDX_W-1:0]   k;
  logic               spur;

  logic [NUM_IRQ-1:0] req_vec;
  logic               req_valid, isr_valid, win_valid;
  logic [IDX_W-1:0]   req_idx, isr_idx;
  logic               eoi_hit;
  logic [IDX_W-1:0]   eoi_idx;
  logic [NUM_IRQ-1:0] ack_set, eoi_clr, aeoi_clr, irr_n, isr_n;
  logic [IDX_W-1:0]   lp_n;

  assign req_vec = IRR & ~IMR;

  prio_resolver #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_win (
    .req(req_vec), .lp(lp), .valid(req_valid), .idx(req_idx)
  );

  prio_resolver #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_isr (
    .req(ISR), .lp(lp), .valid(isr_valid), .idx(isr_idx)
  );

  // A request only wins if it outranks everything already in service.
  assign win_valid = req_valid &&
    (!isr_valid || prio_rank(int'(req_idx), int'(lp), NUM_IRQ) <
                   prio_rank(int'(isr_idx), int'(lp), NUM_IRQ));

  always_comb begin
    eoi_hit = 1'b0;
    eoi_idx = isr_idx;
    if (EOI_CMD && ISR != '0) begin
      if (EOI_SPEC == EOI_SPECIFIC) begin
        if (int'(EOI_IDX) < NUM_IRQ) begin
          eoi_hit = 1'b1;
          eoi_idx = EOI_IDX;
        end
      end else begin
        eoi_hit = 1'b1;
      end
    end
  end

  always_comb begin
    ack_set  = '0;
    eoi_clr  = '0;
    aeoi_clr = '0;
    lp_n     = lp;
    if (state == ST_PEND && INTA && win_valid) ack_set = ONE << req_idx;
    if (eoi_hit) begin
      eoi_clr = ONE << eoi_idx;
      if (CFG_ROTATE) lp_n = eoi_idx;
    end
    if (state == ST_ACK && INTA && !spur && CFG_AEOI) begin
      aeoi_clr = ONE << k;
      if (CFG_ROTATE) lp_n = k;
    end
    // EOI sees the pre-acknowledge ISR; a fresh edge beats the acknowledge clear.
    isr_n = (ISR & ~eoi_clr & ~aeoi_clr) | ack_set;
    irr_n = CFG_LEVEL ? IRQ : ((IRR & ~ack_set) | (IRQ & ~irq_prev));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_prev <= '0;
      IRR      <= '0;
      ISR      <= '0;
      IMR      <= '1;
      lp       <= LAST_IDX;
    end else begin
      irq_prev <= IRQ;
      IRR      <= irr_n;
      ISR      <= isr_n;
      lp       <= lp_n;
      if (IMR_WE) IMR <= IMR_DIN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      k         <= LAST_IDX;
      spur      <= 1'b0;
      INT       <= 1'b0;
      VEC       <= '0;
      VEC_VALID <= 1'b0;
    end else begin
      VEC_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (INTA) begin
            state <= ST_ACK;
            k     <= LAST_IDX;
            spur  <= 1'b1;
            INT   <= 1'b0;
          end else if (win_valid) begin
            state <= ST_PEND;
            INT   <= 1'b1;
          end
        end
        ST_PEND: begin
          if (INTA) begin
            state <= ST_ACK;
            INT   <= 1'b0;
            k     <= win_valid ? req_idx : LAST_IDX;
            spur  <= !win_valid;
          end else if (!win_valid) begin
            state <= ST_IDLE;
            INT   <= 1'b0;
          end
        end
        ST_ACK: begin
          if (INTA) begin
            state     <= ST_IDLE;
            VEC       <= (VEC_BASE & ~IDX_MASK) | VEC_W'(k);
            VEC_VALID <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          INT   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_prio_core.sv
// Bench for irq_prio_core: vector table, directed corner sequences, random vs model.
module tb_irq_prio_core;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IRQ, IMR_DIN, VEC_BASE, VEC, IRR, ISR, IMR;
  logic       CFG_LEVEL, CFG_AEOI, CFG_ROTATE, IMR_WE, EOI_CMD, EOI_SPEC, INTA;
  logic [2:0] EOI_IDX;
  logic       INT, VEC_VALID;

  logic [15:0] w_IRQ, w_IMR_DIN, w_IRR, w_ISR, w_IMR;
  logic [7:0]  w_VEC_BASE, w_VEC;
  logic        w_IMR_WE, w_EOI_CMD, w_EOI_SPEC, w_INTA, w_INT, w_VEC_VALID;
  logic [3:0]  w_EOI_IDX;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  irq_prio_core #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .CFG_LEVEL(CFG_LEVEL), .CFG_AEOI(CFG_AEOI),
    .CFG_ROTATE(CFG_ROTATE), .VEC_BASE(VEC_BASE), .IMR_WE(IMR_WE), .IMR_DIN(IMR_DIN),
    .EOI_CMD(EOI_CMD), .EOI_SPEC(EOI_SPEC), .EOI_IDX(EOI_IDX), .INTA(INTA),
    .INT(INT), .VEC(VEC), .VEC_VALID(VEC_VALID), .IRR(IRR), .ISR(ISR), .IMR(IMR)
  );

  irq_prio_core #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
    .CLK(CLK), .RESET(RESET), .IRQ(w_IRQ), .CFG_LEVEL(1'b0), .CFG_AEOI(1'b0),
    .CFG_ROTATE(1'b0), .VEC_BASE(w_VEC_BASE), .IMR_WE(w_IMR_WE), .IMR_DIN(w_IMR_DIN),
    .EOI_CMD(w_EOI_CMD), .EOI_SPEC(w_EOI_SPEC), .EOI_IDX(w_EOI_IDX), .INTA(w_INTA),
    .INT(w_INT), .VEC(w_VEC), .VEC_VALID(w_VEC_VALID), .IRR(w_IRR), .ISR(w_ISR), .IMR(w_IMR)
  );

  // Reference model state (8 channels)
  logic [7:0] m_irr, m_isr, m_imr, m_prev, m_vec;
  int         m_lp, m_phase, m_k;
  logic       m_spur, m_int, m_vv;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] imr;
    logic       exp_int;
    logic [7:0] exp_vec;
    logic [7:0] exp_isr;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_prev = 0; m_vec = 0;
    m_lp = 7; m_phase = 0; m_k = 7; m_spur = 0; m_int = 0; m_vv = 0;
  endtask

  task automatic do_reset();
    IRQ = 0; IMR_WE = 0; IMR_DIN = 0; EOI_CMD = 0; EOI_SPEC = 0; EOI_IDX = 0; INTA = 0;
    CFG_LEVEL = 0; CFG_AEOI = 0; CFG_ROTATE = 0; VEC_BASE = 8'h40;
    w_IRQ = 0; w_IMR_WE = 0; w_IMR_DIN = 0; w_EOI_CMD = 0; w_EOI_SPEC = 0; w_EOI_IDX = 0;
    w_INTA = 0; w_VEC_BASE = 8'hA0;
    RESET = 0;
    cyc(); cyc();
    RESET = 1;
    cyc();
    model_reset();
  endtask

  task automatic set_imr(input logic [7:0] v);
    IMR_WE = 1; IMR_DIN = v; cyc(); IMR_WE = 0;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    IRQ = v; cyc(); IRQ = 0; cyc();
  endtask

  // Two INTA pulses with a gap; returns after the cycle carrying VEC_VALID.
  task automatic ack2();
    INTA = 1; cyc(); INTA = 0; cyc();
    INTA = 1; cyc(); INTA = 0;
  endtask

  function automatic int pri(input int i, input int lp);
    return (i - lp - 1 + 8) % 8;
  endfunction

  // Next-state of the controller from the rules, sampled at the coming edge.
  task automatic model_step();
    int best, best_p, top, top_p, tgt;
    logic win;
    logic [7:0] n_irr, n_isr;
    int n_lp;
    best = -1; best_p = 99; top = -1; top_p = 99;
    for (int i = 0; i < 8; i++) begin
      if (m_irr[i] && !m_imr[i] && pri(i, m_lp) < best_p) begin best = i; best_p = pri(i, m_lp); end
      if (m_isr[i] && pri(i, m_lp) < top_p) begin top = i; top_p = pri(i, m_lp); end
    end
    win = (best >= 0) && (best_p < top_p);
    n_irr = m_irr; n_isr = m_isr; n_lp = m_lp; m_vv = 0;
    if (EOI_CMD && m_isr != 0) begin
      tgt = EOI_SPEC ? int'(EOI_IDX) : top;
      n_isr[tgt] = 0;
      if (CFG_ROTATE) n_lp = tgt;
    end
    if (m_phase == 0) begin
      if (INTA) begin m_phase = 2; m_k = 7; m_spur = 1; m_int = 0; end
      else if (win) begin m_phase = 1; m_int = 1; end
    end else if (m_phase == 1) begin
      if (INTA) begin
        m_phase = 2; m_int = 0;
        if (win) begin m_k = best; m_spur = 0; n_isr[best] = 1; n_irr[best] = 0; end
        else begin m_k = 7; m_spur = 1; end
      end else if (!win) begin m_phase = 0; m_int = 0; end
    end else begin
      if (INTA) begin
        m_phase = 0; m_vv = 1;
        m_vec = (VEC_BASE & 8'hF8) | 8'(m_k);
        if (CFG_AEOI && !m_spur) begin
          n_isr[m_k] = 0;
          if (CFG_ROTATE) n_lp = m_k;
        end
      end
    end
    if (CFG_LEVEL) n_irr = IRQ;
    else n_irr = n_irr | (IRQ & ~m_prev);
    if (IMR_WE) m_imr = IMR_DIN;
    m_prev = IRQ; m_irr = n_irr; m_isr = n_isr; m_lp = n_lp;
  endtask

  initial begin
    tbl[0] = '{8'h08, 8'h00, 1'b1, 8'h43, 8'h08};
    tbl[1] = '{8'h28, 8'h00, 1'b1, 8'h43, 8'h08};
    tbl[2] = '{8'h28, 8'h08, 1'b1, 8'h45, 8'h20};
    tbl[3] = '{8'h81, 8'h00, 1'b1, 8'h40, 8'h01};
    tbl[4] = '{8'h80, 8'h00, 1'b1, 8'h47, 8'h80};
    tbl[5] = '{8'h10, 8'hFF, 1'b0, 8'h47, 8'h00};
    tbl[6] = '{8'hF0, 8'h30, 1'b1, 8'h46, 8'h40};

    // Reset state
    do_reset();
    chk("rst_int", 32'(INT), 0);
    chk("rst_vec", 32'(VEC), 0);
    chk("rst_vv", 32'(VEC_VALID), 0);
    chk("rst_irr_isr", {16'(IRR), 16'(ISR)}, 0);
    chk("rst_imr", 32'(IMR), 32'hFF);
    chk("rst_imr16", 32'(w_IMR), 32'hFFFF);

    // Table: single-shot acknowledge scenarios, edge mode, LP = 7
    for (int t = 0; t < 7; t++) begin
      do_reset();
      set_imr(tbl[t].imr);
      pulse_irq(tbl[t].irq);
      chk($sformatf("tbl%0d_int", t), 32'(INT), 32'(tbl[t].exp_int));
      ack2();
      chk($sformatf("tbl%0d_vv", t), 32'(VEC_VALID), 1);
      chk($sformatf("tbl%0d_vec", t), 32'(VEC), 32'(tbl[t].exp_vec));
      chk($sformatf("tbl%0d_isr", t), 32'(ISR), 32'(tbl[t].exp_isr));
      cyc();
      chk($sformatf("tbl%0d_vv_off", t), {31'(VEC), VEC_VALID}, {31'(tbl[t].exp_vec), 1'b0});
    end

    // INT latency: IRR one cycle after the edge, INT the cycle after that
    do_reset();
    set_imr(8'h00);
    IRQ = 8'h08; cyc(); IRQ = 0;
    chk("lat_irr_t1", 32'(IRR), 32'h08);
    chk("lat_int_t1", 32'(INT), 0);
    cyc();
    chk("lat_int_t2", 32'(INT), 1);

    // IMR write lands one cycle later; masking drops a pending INT
    set_imr(8'h08);
    chk("imr_applied", 32'(IMR), 32'h08);
    cyc();
    chk("imr_int_drop", 32'(INT), 0);

    // Nesting and non-specific EOI
    do_reset();
    set_imr(8'h00);
    pulse_irq(8'h08);
    ack2();
    chk("nest_isr3", 32'(ISR), 32'h08);
    pulse_irq(8'h20); cyc();
    chk("nest_low_blocked", 32'(INT), 0);
    pulse_irq(8'h02);
    chk("nest_high_int", 32'(INT), 1);
    ack2();
    chk("nest_vec1", 32'(VEC), 32'h41);
    chk("nest_isr", 32'(ISR), 32'h0A);
    EOI_CMD = 1; EOI_SPEC = 0; cyc(); EOI_CMD = 0;
    chk("nest_eoi_first", 32'(ISR), 32'h08);
    EOI_CMD = 1; cyc(); EOI_CMD = 0;
    chk("nest_eoi_second", 32'(ISR), 32'h00);
    cyc();
    chk("nest_pending5", 32'(INT), 1);

    // Rotation on EOI moves the lowest priority to the cleared channel
    do_reset();
    CFG_ROTATE = 1;
    set_imr(8'h00);
    pulse_irq(8'h04);
    ack2();
    chk("rot_isr2", 32'(ISR), 32'h04);
    EOI_CMD = 1; EOI_SPEC = 0; cyc(); EOI_CMD = 0;
    chk("rot_eoi", 32'(ISR), 32'h00);
    pulse_irq(8'h0C);
    ack2();
    chk("rot_vec3", 32'(VEC), 32'h43);

    // Level mode request withdrawn before acknowledge gives spurious vector
    do_reset();
    CFG_LEVEL = 1;
    set_imr(8'h00);
    IRQ = 8'h40; cyc(); cyc();
    chk("lvl_int", 32'(INT), 1);
    IRQ = 0; cyc(); cyc();
    chk("lvl_int_drop", {31'(IRR), INT}, 0);
    ack2();
    chk("lvl_spur_vec", {31'(VEC), VEC_VALID}, {31'(8'h47), 1'b1});
    chk("lvl_spur_isr", 32'(ISR), 0);

    // Automatic EOI, then reset in the middle of an acknowledge
    do_reset();
    CFG_AEOI = 1;
    set_imr(8'h00);
    pulse_irq(8'h01);
    INTA = 1; cyc(); INTA = 0;
    chk("aeoi_isr_mid", 32'(ISR), 32'h01);
    cyc();
    INTA = 1; cyc(); INTA = 0;
    chk("aeoi_vec", {31'(VEC), VEC_VALID}, {31'(8'h40), 1'b1});
    chk("aeoi_isr_clr", 32'(ISR), 0);
    pulse_irq(8'h04);
    INTA = 1; cyc(); INTA = 0;
    RESET = 0; #1;
    chk("rst_mid_imr", 32'(IMR), 32'hFF);
    chk("rst_mid_out", {29'(VEC), VEC_VALID, INT, 1'b0}, 0);
    cyc();
    RESET = 1;
    cyc();
    INTA = 1; cyc(); INTA = 0;
    chk("rst_mid_no_vv", 32'(VEC_VALID), 0);
    chk("rst_mid_isr", 32'(ISR), 0);

    // 16-channel instance: top channel and specific EOI
    do_reset();
    w_IMR_WE = 1; w_IMR_DIN = 0; cyc(); w_IMR_WE = 0;
    w_IRQ = 16'h8000; cyc(); w_IRQ = 0; cyc();
    chk("w_int", 32'(w_INT), 1);
    w_INTA = 1; cyc(); w_INTA = 0; cyc();
    w_INTA = 1; cyc(); w_INTA = 0;
    chk("w_vec", {31'(w_VEC), w_VEC_VALID}, {31'(8'hAF), 1'b1});
    chk("w_isr", 32'(w_ISR), 32'h8000);
    w_EOI_CMD = 1; w_EOI_SPEC = 1; w_EOI_IDX = 4'd15; cyc(); w_EOI_CMD = 0;
    chk("w_eoi15", 32'(w_ISR), 0);

    // Random stimulus against the reference model
    for (int b = 0; b < 4; b++) begin
      do_reset();
      CFG_LEVEL = 1'($urandom); CFG_AEOI = 1'($urandom); CFG_ROTATE = 1'($urandom);
      VEC_BASE = 8'($urandom);
      for (int c = 0; c < 400; c++) begin
        IRQ = IRQ ^ 8'($urandom & $urandom & $urandom);
        IMR_WE = ($urandom_range(0, 15) == 0);
        IMR_DIN = 8'($urandom & $urandom);
        EOI_CMD = ($urandom_range(0, 9) == 0);
        EOI_SPEC = 1'($urandom);
        EOI_IDX = 3'($urandom);
        INTA = ($urandom_range(0, 3) == 0);
        model_step();
        cyc();
        n_vec++;
        if (INT !== m_int || VEC !== m_vec || VEC_VALID !== m_vv ||
            IRR !== m_irr || ISR !== m_isr || IMR !== m_imr) begin
          n_err++;
          $display("FAIL rand b%0d c%0d: got int=%b vec=%h vv=%b irr=%h isr=%h imr=%h, want int=%b vec=%h vv=%b irr=%h isr=%h imr=%h",
                   b, c, INT, VEC, VEC_VALID, IRR, ISR, IMR, m_int, m_vec, m_vv, m_irr, m_isr, m_imr);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_prio_core.md
IRQ_PRIO_CORE -- requirements
Module: irq_prio_core

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels (legal 2..16).
REQ-002 SHALL have parameter VEC_W, default 8, vector width (VEC_W >= IDX_W).
REQ-003 SHALL derive localparam IDX_W = clog2(NUM_IRQ), channel index width.
REQ-004 SHALL have ports:
- CLK  in  1  clock.
- RESET  in  1  reset; asynchronous, active-low.
- IRQ  in  NUM_IRQ  request lines, synchronous to CLK.
- CFG_LEVEL  in  1  1 = level-triggered, 0 = edge-triggered.
- CFG_AEOI  in  1  automatic EOI.
- CFG_ROTATE  in  1  rotate priority on EOI.
- VEC_BASE  in  VEC_W  vector base; low IDX_W bits ignored.
- IMR_WE  in  1  mask write strobe.
- IMR_DIN  in  NUM_IRQ  mask data, 1 = masked.
- EOI_CMD  in  1  one-cycle EOI strobe.
- EOI_SPEC  in  1  1 = specific EOI, 0 = non-specific.
- EOI_IDX  in  IDX_W  channel for specific EOI.
- INTA  in  1  one-cycle acknowledge strobe.
- INT  out  1  interrupt request to CPU.
- VEC  out  VEC_W  acknowledged vector.
- VEC_VALID  out  1  one-cycle vector strobe.
- IRR, ISR, IMR  out  NUM_IRQ  request, in-service and mask registers.

Function
REQ-005 SHALL set IRR[i] in edge mode on a 0->1 transition of IRQ[i] against its registered previous sample, and in level mode whenever IRQ[i] = 1.
REQ-006 SHALL clear level-mode IRR[i] when IRQ[i] = 0; edge-mode IRR[i] holds until acknowledged.
REQ-007 SHALL hold priority pointer LP (lowest-priority channel); priority descends from (LP+1) mod NUM_IRQ to LP.
REQ-008 SHALL select the winner as the highest-priority bit of IRR & ~IMR whose priority is strictly above every ISR bit (fully nested).
REQ-009 SHALL run FSM IDLE/PEND/ACK with these transitions:
- IDLE->PEND when a winner exists; INT = 1 registered, so an IRQ edge at cycle t gives IRR at t+1 and INT at t+2.
- PEND->IDLE, INT -> 0, if no winner remains before INTA.
- PEND + INTA -> ACK: latch winner k, set ISR[k], clear IRR[k], INT -> 0.
- ACK + INTA -> IDLE: VEC = {VEC_BASE[VEC_W-1:IDX_W], k}, VEC_VALID = 1 for exactly one cycle, VEC held until the next acknowledge.
REQ-010 SHALL treat INTA in IDLE as spurious: no ISR change, FSM -> ACK with k = NUM_IRQ-1 flagged spurious; the second INTA returns that vector and sets no ISR bit.
REQ-011 SHALL, when CFG_AEOI = 1, clear ISR[k] in the cycle of the second INTA (not for spurious); if CFG_ROTATE = 1 also set LP = k.
REQ-012 SHALL handle EOI_CMD:
- Non-specific: clears the highest-priority set ISR bit.
- Specific: clears ISR[EOI_IDX].
- If CFG_ROTATE = 1, LP = cleared index.
- ISR empty or EOI_IDX >= NUM_IRQ: no effect.
REQ-013 SHALL apply an IMR write in the cycle after IMR_WE; a winner latched in the same cycle uses the pre-write IMR.
REQ-014 SHALL let a new edge on IRQ[k] in the same cycle as the first INTA for k leave IRR[k] = 1 (set wins).
REQ-015 SHALL, for EOI_CMD coincident with the first INTA, evaluate EOI against ISR before the INTA set; both updates take effect.
REQ-016 SHALL ignore INTA while in ACK for anything other than completing the second-pulse sequence.

Reset
REQ-017 SHALL, on RESET = 0, asynchronously set state = IDLE, IRR = ISR = 0, IMR = all ones, LP = NUM_IRQ-1, IRQ samples = 0, INT = 0, VEC = 0, VEC_VALID = 0.
REQ-018 SHALL abandon any acknowledge in progress on reset without emitting VEC_VALID.

Structure
REQ-019 SHALL place the FSM state enum (IDLE, PEND, ACK) and EOI mode constants in shared package pic_pkg.
REQ-020 SHALL implement rotating find-first-set as combinational sub-module prio_resolver (inputs: request vector, LP; outputs: valid, index), instantiated for both winner selection and non-specific EOI.

Verification
REQ-021 SHALL cover reset + IMR = 0x00, edge IRQ[3] -> INT at t+2; two INTA -> VEC = 0x43 with VEC_BASE = 0x40; ISR = 0x08.
REQ-022 SHALL cover ISR[3] set, IRQ[5] edge -> INT stays 0; IRQ[1] edge -> INT = 1 (nesting); non-specific EOI clears ISR[1] first.
REQ-023 SHALL cover CFG_ROTATE = 1, ISR[2] cleared by EOI -> LP = 2; then IRQ[2] and IRQ[3] together -> VEC low bits = 3.
REQ-024 SHALL cover CFG_LEVEL = 1, IRQ[6] dropped after INT, before first INTA -> spurious VEC = 0x47, ISR unchanged.
REQ-025 SHALL cover CFG_AEOI = 1, IRQ[0] -> ISR[0] = 0 after the second INTA; RESET mid-ACK -> no VEC_VALID, IMR = 0xFF.
REQ-026 SHALL cover NUM_IRQ = 16, VEC_W = 8, IRQ[15] -> VEC = {VEC_BASE[7:4], 4'hF}; specific EOI_IDX = 15 clears ISR[15].
